// File: rtl/card_game_sequencer_if.sv
// card_game_sequencer_if: debounced player request levels in, game status and display data out.
interface card_game_sequencer_if #(parameter int SUM_W = 5);
    logic             start, p1_hit, p1_stand, p2_hit, p2_stand;
    logic [SUM_W-1:0] p1_sum, p2_sum;
    logic [3:0]       p1_first, p2_first, last_card;
    logic             card_valid, p1_bust, p2_bust;
    logic [1:0]       turn, winner;
    modport master (
        output start, p1_hit, p1_stand, p2_hit, p2_stand,
        input  p1_sum, p2_sum, p1_first, p2_first, last_card, card_valid, turn, p1_bust, p2_bust, winner
    );
    modport slave (
        input  start, p1_hit, p1_stand, p2_hit, p2_stand,
        output p1_sum, p2_sum, p1_first, p2_first, last_card, card_valid, turn, p1_bust, p2_bust, winner
    );
endinterface

// File: rtl/card_game_sequencer.sv
// card_game_sequencer: two-player 21-points turn sequencer sharing one free-running card source.
module card_game_sequencer #(
    parameter int TARGET   = 21,
    parameter int CARD_MAX = 10,
    parameter int SUM_W    = 5
) (
    input logic                  kHz,
    input logic                  Reset,
    card_game_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_D1, S_D2, S_P1, S_P2, S_RESULT, S_DONE} state_t;
    state_t           r_state;
    logic [3:0]       r_card, r_p1_first, r_p2_first, r_last_card;
    logic [SUM_W-1:0] r_p1_sum, r_p2_sum;
    logic             r_card_valid, r_p1_bust, r_p2_bust;
    logic [1:0]       r_turn, r_winner;
    logic             r_start_q, r_p1_hit_q, r_p1_stand_q, r_p2_hit_q, r_p2_stand_q;
    logic             w_start_e, w_p1_hit_e, w_p1_stand_e, w_p2_hit_e, w_p2_stand_e;
    logic [SUM_W-1:0] w_card, w_p1_next, w_p2_next;

    assign w_start_e    = bus.start    & ~r_start_q;
    assign w_p1_hit_e   = bus.p1_hit   & ~r_p1_hit_q;
    assign w_p1_stand_e = bus.p1_stand & ~r_p1_stand_q;
    assign w_p2_hit_e   = bus.p2_hit   & ~r_p2_hit_q;
    assign w_p2_stand_e = bus.p2_stand & ~r_p2_stand_q;
    assign w_card       = SUM_W'(r_card);
    assign w_p1_next    = r_p1_sum + w_card;
    assign w_p2_next    = r_p2_sum + w_card;

    always_ff @(posedge kHz or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_card       <= 4'd1;
            r_p1_first   <= '0;
            r_p2_first   <= '0;
            r_last_card  <= '0;
            r_p1_sum     <= '0;
            r_p2_sum     <= '0;
            r_card_valid <= 1'b0;
            r_p1_bust    <= 1'b0;
            r_p2_bust    <= 1'b0;
            r_turn       <= 2'b00;
            r_winner     <= 2'b00;
            r_start_q    <= 1'b0;
            r_p1_hit_q   <= 1'b0;
            r_p1_stand_q <= 1'b0;
            r_p2_hit_q   <= 1'b0;
            r_p2_stand_q <= 1'b0;
        end else begin
            r_card       <= (r_card == 4'(CARD_MAX)) ? 4'd1 : r_card + 4'd1;
            r_start_q    <= bus.start;
            r_p1_hit_q   <= bus.p1_hit;
            r_p1_stand_q <= bus.p1_stand;
            r_p2_hit_q   <= bus.p2_hit;
            r_p2_stand_q <= bus.p2_stand;
            r_card_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: if (w_start_e) r_state <= S_D1;
                S_D1: begin
                    r_p1_first   <= r_card;
                    r_p1_sum     <= w_card;
                    r_last_card  <= r_card;
                    r_card_valid <= 1'b1;
                    r_p2_first   <= '0;
                    r_p2_sum     <= '0;
                    r_p1_bust    <= 1'b0;
                    r_p2_bust    <= 1'b0;
                    r_winner     <= 2'b00;
                    r_state      <= S_D2;
                end
                S_D2: begin
                    r_p2_first   <= r_card;
                    r_p2_sum     <= w_card;
                    r_last_card  <= r_card;
                    r_card_valid <= 1'b1;
                    r_turn       <= 2'b01;
                    r_state      <= S_P1;
                end
                // stand takes priority over a simultaneous hit
                S_P1: if (w_p1_stand_e) begin
                    r_turn  <= 2'b10;
                    r_state <= S_P2;
                end else if (w_p1_hit_e) begin
                    r_p1_sum     <= w_p1_next;
                    r_last_card  <= r_card;
                    r_card_valid <= 1'b1;
                    if (w_p1_next > SUM_W'(TARGET)) begin
                        r_p1_bust <= 1'b1;
                        r_turn    <= 2'b00;
                        r_state   <= S_RESULT;
                    end
                end
                S_P2: if (w_p2_stand_e) begin
                    r_turn  <= 2'b00;
                    r_state <= S_RESULT;
                end else if (w_p2_hit_e) begin
                    r_p2_sum     <= w_p2_next;
                    r_last_card  <= r_card;
                    r_card_valid <= 1'b1;
                    if (w_p2_next > SUM_W'(TARGET)) begin
                        r_p2_bust <= 1'b1;
                        r_turn    <= 2'b00;
                        r_state   <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    r_winner <= r_p1_bust ? 2'b10 : r_p2_bust ? 2'b01 :
                                (r_p1_sum > r_p2_sum) ? 2'b01 : (r_p2_sum > r_p1_sum) ? 2'b10 : 2'b11;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.p1_sum     = r_p1_sum;
    assign bus.p2_sum     = r_p2_sum;
    assign bus.p1_first   = r_p1_first;
    assign bus.p2_first   = r_p2_first;
    assign bus.last_card  = r_last_card;
    assign bus.card_valid = r_card_valid;
    assign bus.turn       = r_turn;
    assign bus.p1_bust    = r_p1_bust;
    assign bus.p2_bust    = r_p2_bust;
    assign bus.winner     = r_winner;
endmodule
